// File: rtl/sm_mac_pipe.sv
// sm_mac_pipe: two-stage sign-magnitude multiply-accumulate.
// Stage 1 decodes both sign-magnitude operands and registers their product.
// Stage 2 adds products into a saturating accumulator and counts the terms.
// A three-state controller (IDLE/RUN/HOLD) presents each finished dot
// product until downstream takes it.
// Optional build macro: SM_MAC_RELU_EN clamps negative results to zero.
//
// Handshake: an input pair transfers on a cycle where iValid & oReady; a
// result transfers on a cycle where oValid & iReady. oReady is low only while
// a result is held and iReady is low, and during that stall every pipeline
// register keeps its value.
module sm_mac_pipe #(
  parameter int BIT   = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 10
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [BIT-1:0]   iNum1,
  input  logic [BIT-1:0]   iNum2,
  input  logic             iLast,
  output logic             oValid,
  input  logic             iReady,
  output logic [ACC_W-1:0] oAcc,
  output logic [CNT_W-1:0] oCount,
  output logic             oSat
);

  localparam int PW = 2 * BIT;   // product width, two's complement
  localparam int SW = ACC_W + 2; // sum width, wide enough to never overflow

  // Largest magnitude representable in the sign-magnitude result.
  localparam logic signed [SW-1:0] SUM_MAX = $signed({3'b000, {(ACC_W-1){1'b1}}});
  localparam logic signed [SW-1:0] SUM_MIN = -SUM_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Controller state; kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_nx;

  // Sign-magnitude code to signed value; sign with zero magnitude is unity.
  function automatic logic signed [BIT:0] decode(input logic [BIT-1:0] code);
    logic [BIT-2:0]      mag;
    logic signed [BIT:0] v;
    mag = code[BIT-2:0];
    v   = '0;
    if (mag == '0) begin
      if (code[BIT-1]) v[BIT-1] = 1'b1;
    end else begin
      v = $signed({2'b00, mag});
      if (code[BIT-1]) v = -v;
    end
    return v;
  endfunction

  logic signed [BIT:0]    val1, val2;
  logic signed [PW-1:0]   ext1, ext2;
  logic signed [PW-1:0]   prod;
  logic                   stall;

  logic                   s1_valid;
  logic                   s1_last;
  logic signed [PW-1:0]   s1_prod;

  logic signed [ACC_W:0]  acc, acc_nx, base_acc;
  logic [CNT_W-1:0]       cnt, cnt_nx, base_cnt;
  logic                   sat, sat_nx, base_sat;
  logic                   take;
  logic signed [SW-1:0]   sum, clipped;
  logic                   clamp;

  logic                   neg;
  logic [ACC_W-2:0]       mag_out;

  // Operand decode and product; every product fits in PW signed bits.
  always_comb begin
    val1 = decode(iNum1);
    val2 = decode(iNum2);
    ext1 = {{(PW-BIT-1){val1[BIT]}}, val1};
    ext2 = {{(PW-BIT-1){val2[BIT]}}, val2};
    prod = ext1 * ext2;
  end

  assign stall  = oValid & ~iReady;
  assign oReady = ~stall;

  // Stage 1: capture product, last flag and valid whenever not stalled.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (!stall) begin
      s1_valid <= iValid;
      s1_last  <= iLast;
      s1_prod  <= prod;
    end
  end

  // State register together with the accumulator, term counter and sticky flag.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      sat   <= sat_nx;
    end
  end

  // Next state and next accumulator; a HOLD transfer restarts from zero and
  // may absorb the next vector's first term in the same cycle.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    sat_nx   = sat;
    base_acc = acc;
    base_cnt = cnt;
    base_sat = sat;
    take     = 1'b0;
    case (state)
      IDLE, RUN: take = s1_valid;
      HOLD: begin
        if (iReady) begin
          base_acc = '0;
          base_cnt = '0;
          base_sat = 1'b0;
          acc_nx   = '0;
          cnt_nx   = '0;
          sat_nx   = 1'b0;
          state_nx = IDLE;
          take     = s1_valid;
        end
      end
      default: state_nx = IDLE;
    endcase

    sum     = {base_acc[ACC_W], base_acc} + {{(SW-PW){s1_prod[PW-1]}}, s1_prod};
    clipped = sum;
    clamp   = 1'b0;
    if (sum > SUM_MAX) begin
      clipped = SUM_MAX;
      clamp   = 1'b1;
    end else if (sum < SUM_MIN) begin
      clipped = SUM_MIN;
      clamp   = 1'b1;
    end

    if (take) begin
      acc_nx   = (ACC_W+1)'(clipped);
      cnt_nx   = base_cnt + CNT_W'(1);
      sat_nx   = base_sat | clamp;
      state_nx = s1_last ? HOLD : RUN;
    end
  end

  // Output decode: result is presented only in HOLD, zero always with sign 0.
  always_comb begin
    neg     = acc[ACC_W];
    mag_out = (ACC_W-1)'(neg ? -acc : acc);
    oValid  = (state == HOLD);
    oAcc    = '0;
    oCount  = '0;
    oSat    = 1'b0;
    if (oValid) begin
`ifdef SM_MAC_RELU_EN
      oAcc = neg ? '0 : {1'b0, mag_out};
`else
      oAcc = {neg, mag_out};
`endif
      oCount = cnt;
      oSat   = sat;
    end
  end

endmodule

// File: tb/tb_sm_mac_pipe.sv
// Directed bench for sm_mac_pipe: two instances (ACC_W=24 and ACC_W=16)
// share all inputs so the saturating width can be observed alongside.
module tb_sm_mac_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        pair_valid;
  logic [7:0]  num1, num2;
  logic        last;
  logic        res_ready;

  logic        ready24, valid24, sat24;
  logic [23:0] acc24;
  logic [9:0]  cnt24;
  logic        ready16, valid16, sat16;
  logic [15:0] acc16;
  logic [9:0]  cnt16;

  logic [23:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  sm_mac_pipe #(.BIT(8), .ACC_W(24), .CNT_W(10)) dut24 (
    .iClk(clk), .iRst_n(rst_n), .iValid(pair_valid), .oReady(ready24),
    .iNum1(num1), .iNum2(num2), .iLast(last), .oValid(valid24),
    .iReady(res_ready), .oAcc(acc24), .oCount(cnt24), .oSat(sat24)
  );

  sm_mac_pipe #(.BIT(8), .ACC_W(16), .CNT_W(10)) dut16 (
    .iClk(clk), .iRst_n(rst_n), .iValid(pair_valid), .oReady(ready16),
    .iNum1(num1), .iNum2(num2), .iLast(last), .oValid(valid16),
    .iReady(res_ready), .oAcc(acc16), .oCount(cnt16), .oSat(sat16)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // Present one pair and return one step after the edge that accepted it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
    int guard;
    guard      = 0;
    pair_valid = 1'b1;
    num1       = a;
    num2       = b;
    last       = l;
    while (!ready24 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("send_timeout", 32'(ready24), 32'd1);
    step();
    pair_valid = 1'b0;
    last       = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_result(input string tag, input logic [9:0] ecnt, input logic esat);
    logic [23:0] e;
    int guard;
    guard = 0;
    e     = 24'hxxxxxx;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed empty expected queue, expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
    end
    while (!valid24 && guard < 20) begin
      step();
      guard++;
    end
    check({tag, "_valid"}, 32'(valid24), 32'd1);
    check({tag, "_acc"},   32'(acc24),   32'(e));
    check({tag, "_cnt"},   32'(cnt24),   32'(ecnt));
    check({tag, "_sat"},   32'(sat24),   32'(esat));
  endtask

  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [23:0] e);
    exp_q.push_back(e);
    send(a, b, 1'b1);
    check({tag, "_lat_early"}, 32'(valid24), 32'd0);
    step();
    check({tag, "_lat_exact"}, 32'(valid24), 32'd1);
    expect_result(tag, 10'd1, 1'b0);
    step();
    check({tag, "_drain"}, 32'(valid24), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n      = 1'b0;
    pair_valid = 1'b0;
    num1       = 8'h00;
    num2       = 8'h00;
    last       = 1'b0;
    res_ready  = 1'b1;
    step();
    step();
    check("rst_valid", 32'(valid24), 32'd0);
    check("rst_acc",   32'(acc24),   32'd0);
    check("rst_cnt",   32'(cnt24),   32'd0);
    check("rst_sat",   32'(sat24),   32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(ready24), 32'd1);
    step();

    // single-term products
    single("zero",  8'h00, 8'h55, 24'h000000);
    single("unneg", 8'h80, 8'h85, 24'h800280);
    single("unun",  8'h80, 8'h80, 24'h004000);

    // two-term vector: -15 + 256 = 241
    exp_q.push_back(24'h0000F1);
    send(8'h85, 8'h03, 1'b0);
    send(8'h80, 8'h02, 1'b1);
    expect_result("vec2", 10'd2, 1'b0);
    step();

    // saturation on the 16-bit instance, 49152 on the 24-bit one
    exp_q.push_back(24'h00C000);
    send(8'h80, 8'h80, 1'b0);
    send(8'h80, 8'h80, 1'b0);
    send(8'h80, 8'h80, 1'b1);
    expect_result("sat24", 10'd3, 1'b0);
    check("sat16_acc", 32'(acc16), 32'h7FFF);
    check("sat16_sat", 32'(sat16), 32'd1);
    check("sat16_cnt", 32'(cnt16), 32'd3);
    step();
    exp_q.push_back(24'h000001);
    send(8'h01, 8'h01, 1'b1);
    expect_result("after_sat24", 10'd1, 1'b0);
    check("after_sat16_acc", 32'(acc16), 32'h0001);
    check("after_sat16_sat", 32'(sat16), 32'd0);
    step();

    // back-pressure: 241 held for 5 cycles, next vector waits in stage 1
    res_ready = 1'b0;
    exp_q.push_back(24'h0000F1);
    send(8'h85, 8'h03, 1'b0);
    send(8'h80, 8'h02, 1'b1);
    exp_q.push_back(24'h000006);
    send(8'h02, 8'h03, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(ready24), 32'd0);
      check("bp_valid", 32'(valid24), 32'd1);
      check("bp_acc",   32'(acc24),   32'h0000F1);
      check("bp_cnt",   32'(cnt24),   32'd2);
      step();
    end
    res_ready = 1'b1;
    #1;
    expect_result("bp_first", 10'd2, 1'b0);
    step();
    expect_result("bp_next", 10'd1, 1'b0);
    step();
    check("bp_drain", 32'(valid24), 32'd0);

    // reset in the middle of a vector
    send(8'h05, 8'h05, 1'b0);
    send(8'h07, 8'h07, 1'b0);
    send(8'h09, 8'h09, 1'b0);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(valid24), 32'd0);
    check("mid_rst_ready", 32'(ready24), 32'd1);
    rst_n = 1'b1;
    step();
    exp_q.push_back(24'h000006);
    send(8'h02, 8'h03, 1'b1);
    step();
    expect_result("post_rst", 10'd1, 1'b0);
    step();

    // negative single term, with or without the clamp-to-zero build
`ifdef SM_MAC_RELU_EN
    exp_q.push_back(24'h000000);
`else
    exp_q.push_back(24'h80000F);
`endif
    send(8'h85, 8'h03, 1'b1);
    step();
    expect_result("neg", 10'd1, 1'b0);
    step();

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sm_mac_pipe.md
Name: sm_mac_pipe

Overview:
- Pipelined sign-magnitude multiply-accumulate unit; computes one neuron dot product over a stream of weight/activation pairs.
- Sits between the weight/feature memory readers and the activation/argmax stage of the DNN datapath.
- Same operand encoding as the existing sign-magnitude multiplier, generalised to BIT width.
- Adds streaming handshake, multi-term accumulation, saturation and back-pressure.

Parameters:
- BIT, 8, operand width: 1 sign bit plus (BIT-1) magnitude bits.
- ACC_W, 24, result width in sign-magnitude; must be >= 2*BIT.
- CNT_W, 10, width of the term counter.

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iValid  input  1  operand pair valid.
- oReady  output  1  unit accepts a pair this cycle.
- iNum1  input  BIT  operand 1, sign-magnitude.
- iNum2  input  BIT  operand 2, sign-magnitude.
- iLast  input  1  qualifies the final pair of a vector.
- oValid  output  1  result valid.
- iReady  input  1  downstream accepts the result.
- oAcc  output  ACC_W  dot-product result, sign-magnitude: MSB sign, ACC_W-1 magnitude bits.
- oCount  output  CNT_W  number of terms in the presented result; wraps modulo 2^CNT_W.
- oSat  output  1  result was saturated.

Behaviour:
- Reset, asynchronous: state IDLE; accumulator 0; counter 0; pipeline valids 0; oValid=0, oAcc=0, oCount=0, oSat=0. oReady=1 as soon as reset releases.
- Operand value decode:
  - all-zero code = 0.
  - sign=1 with magnitude 0 = unity, +2^(BIT-1); the unity sign bit is ignored.
  - any other code = (-1)^sign * magnitude.
- Product = value1*value2 as a signed integer.
  - unity x unity = +2^(2*BIT-2).
  - all other products have |p| < 2^(2*BIT-2).
- Transfer rules:
  - Input transfer occurs when iValid & oReady.
  - Output transfer occurs when oValid & iReady.
  - oReady = ~(oValid & ~iReady), combinational.
- Stall: the whole pipeline freezes while oValid=1 and iReady=0. Held operands and oAcc remain stable during the stall.
- Stage 1 registers the product (two's complement, 2*BIT bits), its last flag and a valid bit.
- Stage 2 adds the product into a two's-complement accumulator (ACC_W+1 bits internally) and increments the counter.
- Saturation:
  - Clamp to ±(2^(ACC_W-1)-1) whenever the sum exceeds that range.
  - A sticky saturation flag is set on clamping.
  - Further terms continue from the clamped value.
- State machine:
  - IDLE: accumulator 0, counter 0. First stage-2 term moves to RUN; if that term is also last, go directly to HOLD.
  - RUN: each stage-2 term accumulates. A last term moves to HOLD.
  - HOLD: oValid=1. oAcc is the accumulator converted to sign-magnitude; zero is always presented with sign 0. oCount and oSat are presented alongside.
    - On output transfer: clear accumulator, counter and sticky flag, go to IDLE.
    - Stage 1 may already hold the next vector's first term. It enters stage 2 in the same cycle as the transfer, and the state goes to RUN (or HOLD if that term was last).
- Latency: the last pair accepted at cycle t gives oValid=1 at t+2 when there is no stall. Throughput is one pair per cycle.
- Zero-length vectors are not produced: every vector has at least one pair, and the last one carries iLast.
- Counter wraps modulo 2^CNT_W; the wrap is not flagged.
- Reset mid-vector discards all partial state and in-flight terms.

Optional Feature:
- Macro: SM_MAC_RELU_EN.
- Defined: in HOLD, a negative result is presented as oAcc=0 (sign 0). oSat still reflects saturation that occurred during accumulation. Adds no latency.
- Undefined: negative results are presented with sign bit 1 and their magnitude.

Test Plan:
- Single-term products, one iLast pair each, BIT=8, ACC_W=24:
  - 0x00*0x55 -> oAcc=0x000000.
  - 0x80*0x85 -> -640, oAcc=0x800280.
  - 0x80*0x80 -> oAcc=0x004000.
  - oCount=1 for each; oValid exactly 2 cycles after acceptance.
- Vector (0x85,0x03), then (0x80,0x02) with iLast -> -15+256=241, oAcc=0x0000F1, oCount=2, oSat=0.
- ACC_W=16, three (0x80,0x80) pairs, last on the third -> oAcc=0x7FFF, oSat=1. The next vector (0x01,0x01) -> oAcc=0x0001, oSat=0.
- Back-pressure:
  - Hold iReady=0 for 5 cycles with result 241 presented -> oReady=0; oAcc, oValid, oCount stable; next-vector pair in stage 1 not lost.
  - After iReady=1, next result correct.
- Deassert iRst_n mid-vector after 3 pairs, release, send (0x02,0x03) with last -> oAcc=0x000006, oCount=1.
- SM_MAC_RELU_EN defined: (0x85,0x03) with last -> oAcc=0x000000. Undefined: same stimulus -> oAcc=0x80000F.
